// File: rtl/frog_hop_ctrl_pkg.sv
// Shared types and keycode constants for the Frogger hop controller.
package frog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOP   = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } frog_state_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    localparam logic [15:0] KEY_W     = 16'h001A;
    localparam logic [15:0] KEY_A     = 16'h0004;
    localparam logic [15:0] KEY_S     = 16'h0016;
    localparam logic [15:0] KEY_D     = 16'h0007;
    localparam logic [15:0] KEY_ENTER = 16'h0028;

endpackage

// File: rtl/frog_hop_ctrl_if.sv
// Frog controller bundle: keyboard/lane inputs in, sprite position and status out.
interface frog_hop_ctrl_if;

    logic [15:0] keycode;
    logic        collision;
    logic [9:0]  ride_dx;
    logic [9:0]  FrogX;
    logic [9:0]  FrogY;
    logic [9:0]  FrogS;
    logic [1:0]  frog_state;
    logic [1:0]  lives;
    logic        goal_pulse;
    logic        game_over;

    // master is the frog controller; slave is the lane logic / colour mapper side
    modport master (
        input  keycode, collision, ride_dx,
        output FrogX, FrogY, FrogS, frog_state, lives, goal_pulse, game_over
    );

    modport slave (
        output keycode, collision, ride_dx,
        input  FrogX, FrogY, FrogS, frog_state, lives, goal_pulse, game_over
    );

endinterface

// File: rtl/frog_hop_ctrl_key_edge.sv
// Keyboard edge detector: one-frame strobes for a new direction key or Enter.
module frog_key_edge
    import frog_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keycode,
    output logic        valid,
    output dir_t        dir,
    output logic        enter_strobe
);

    logic [15:0] key_prev;
    logic        changed;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev <= '0;
        end else begin
            key_prev <= keycode;
        end
    end

    assign changed = (keycode != key_prev);

    always_comb begin
        valid = 1'b0;
        dir   = UP;
        case (keycode)
            KEY_W: begin valid = changed; dir = UP;    end
            KEY_A: begin valid = changed; dir = LEFT;  end
            KEY_S: begin valid = changed; dir = DOWN;  end
            KEY_D: begin valid = changed; dir = RIGHT; end
            default: ;
        endcase
    end

    assign enter_strobe = changed && (keycode == KEY_ENTER);

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frame-rate frog sequencer: discrete hops, log drift, death/respawn, lives, goal and game-over.
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int X_START      = 320,
    parameter int Y_START      = 435,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 639,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 479,
    parameter int FROG_SIZE    = 4,
    parameter int HOP_DIST     = 32,
    parameter int HOP_FRAMES   = 8,
    parameter int GOAL_Y       = 35,
    parameter int DEATH_FRAMES = 60,
    parameter int LIVES_INIT   = 3
) (
    input  logic           frame_clk,
    input  logic           Reset,
    frog_hop_ctrl_if.master bus
);

    localparam int HC_W = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;
    localparam int DC_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    localparam logic [9:0]      X_START_P = 10'(X_START);
    localparam logic [9:0]      Y_START_P = 10'(Y_START);
    localparam logic [9:0]      STEP      = 10'(HOP_DIST / HOP_FRAMES);
    localparam logic [9:0]      GOAL_P    = 10'(GOAL_Y);
    localparam logic [1:0]      LIVES_P   = 2'(LIVES_INIT);
    localparam logic [9:0]      X_LO      = 10'(X_MIN + FROG_SIZE);
    localparam logic [9:0]      X_HI      = 10'(X_MAX - FROG_SIZE);
    localparam logic [10:0]     X_LO_W    = 11'(X_MIN + FROG_SIZE);
    localparam logic [10:0]     X_HI_W    = 11'(X_MAX - FROG_SIZE);
    localparam logic [10:0]     Y_HI_W    = 11'(Y_MAX - FROG_SIZE);
    localparam logic [10:0]     UP_MIN    = 11'(Y_MIN + FROG_SIZE + HOP_DIST);
    localparam logic [10:0]     LEFT_MIN  = 11'(X_MIN + FROG_SIZE + HOP_DIST);
    localparam logic [10:0]     HOP_W     = 11'(HOP_DIST);
    localparam logic [HC_W-1:0] HOP_LAST  = HC_W'(HOP_FRAMES - 1);
    localparam logic [DC_W-1:0] DEATH_LAST = DC_W'(DEATH_FRAMES - 1);

    frog_state_t     state_q, state_d;
    dir_t            dir_q, dir_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [1:0]      lives_q, lives_d;
    logic            goal_q, goal_d;
    logic [HC_W-1:0] hop_cnt_q, hop_cnt_d;
    logic [DC_W-1:0] death_cnt_q, death_cnt_d;

    logic            press_valid;
    dir_t            press_dir;
    logic            enter_strobe;
    logic            in_bounds;
    logic [10:0]     drift_sum;
    logic [9:0]      drift_x;
    logic [9:0]      step_x;
    logic [9:0]      step_y;

    frog_key_edge u_key_edge (
        .clk          (frame_clk),
        .rst          (Reset),
        .keycode      (bus.keycode),
        .valid        (press_valid),
        .dir          (press_dir),
        .enter_strobe (enter_strobe)
    );

    always_comb begin
        in_bounds = 1'b0;
        case (press_dir)
            UP:    in_bounds = ({1'b0, y_q} >= UP_MIN);
            DOWN:  in_bounds = ({1'b0, y_q} + HOP_W <= Y_HI_W);
            LEFT:  in_bounds = ({1'b0, x_q} >= LEFT_MIN);
            RIGHT: in_bounds = ({1'b0, x_q} + HOP_W <= X_HI_W);
            default: in_bounds = 1'b0;
        endcase
    end

    // With a negative drift, bit 10 of the 11-bit sum flags underflow below zero;
    // with a non-negative drift the sum never exceeds 11 bits, so it is compared unsigned.
    assign drift_sum = {1'b0, x_q} + {bus.ride_dx[9], bus.ride_dx};

    always_comb begin
        if (bus.ride_dx[9] && drift_sum[10]) begin
            drift_x = X_LO;
        end else if (drift_sum < X_LO_W) begin
            drift_x = X_LO;
        end else if (drift_sum > X_HI_W) begin
            drift_x = X_HI;
        end else begin
            drift_x = drift_sum[9:0];
        end
    end

    always_comb begin
        step_x = x_q;
        step_y = y_q;
        case (dir_q)
            UP:    step_y = y_q - STEP;
            DOWN:  step_y = y_q + STEP;
            LEFT:  step_x = x_q - STEP;
            RIGHT: step_x = x_q + STEP;
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            dir_q       <= UP;
            x_q         <= X_START_P;
            y_q         <= Y_START_P;
            lives_q     <= LIVES_P;
            goal_q      <= 1'b0;
            hop_cnt_q   <= '0;
            death_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            x_q         <= x_d;
            y_q         <= y_d;
            lives_q     <= lives_d;
            goal_q      <= goal_d;
            hop_cnt_q   <= hop_cnt_d;
            death_cnt_q <= death_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        x_d         = x_q;
        y_d         = y_q;
        lives_d     = lives_q;
        goal_d      = 1'b0;
        hop_cnt_d   = hop_cnt_q;
        death_cnt_d = death_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.collision) begin
                    state_d     = DYING;
                    death_cnt_d = '0;
                end else if (press_valid) begin
                    // An out-of-bounds press is consumed: no hop and no drift this frame.
                    if (in_bounds) begin
                        state_d   = HOP;
                        dir_d     = press_dir;
                        hop_cnt_d = '0;
                    end
                end else begin
                    x_d = drift_x;
                end
            end

            HOP: begin
                if (bus.collision) begin
                    state_d     = DYING;
                    death_cnt_d = '0;
                end else begin
                    x_d = step_x;
                    y_d = step_y;
                    if (hop_cnt_q == HOP_LAST) begin
                        hop_cnt_d = '0;
                        state_d   = IDLE;
                        if (step_y <= GOAL_P) begin
                            goal_d = 1'b1;
                            x_d    = X_START_P;
                            y_d    = Y_START_P;
                        end
                    end else begin
                        hop_cnt_d = hop_cnt_q + HC_W'(1);
                    end
                end
            end

            DYING: begin
                if (death_cnt_q == DEATH_LAST) begin
                    death_cnt_d = '0;
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        x_d     = X_START_P;
                        y_d     = Y_START_P;
                        state_d = IDLE;
                    end
                end else begin
                    death_cnt_d = death_cnt_q + DC_W'(1);
                end
            end

            OVER: begin
                if (enter_strobe) begin
                    state_d     = IDLE;
                    dir_d       = UP;
                    x_d         = X_START_P;
                    y_d         = Y_START_P;
                    lives_d     = LIVES_P;
                    hop_cnt_d   = '0;
                    death_cnt_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.FrogX      = x_q;
    assign bus.FrogY      = y_q;
    assign bus.FrogS      = 10'(FROG_SIZE);
    assign bus.frog_state = state_q;
    assign bus.lives      = lives_q;
    assign bus.goal_pulse = goal_q;
    assign bus.game_over  = (state_q == OVER);

endmodule

// File: doc/frog_hop_ctrl.md
Name: frog_hop_ctrl

Overview:
- Frame-rate controller that sequences the player sprite in discrete Frogger hops.
- Replaces free-running per-frame motion: a key press hops the frog exactly one lane or column, animated over HOP_FRAMES frames.
- Also handles log drift, death/respawn timing, lives, goal detection and game-over.
- Feeds FrogX/FrogY/FrogS to the colour mapper; consumes collision/ride info from the lane logic.

Parameters:
X_START, 320, respawn X centre
Y_START, 435, respawn Y centre
X_MIN, 0, leftmost pixel
X_MAX, 639, rightmost pixel
Y_MIN, 0, topmost pixel
Y_MAX, 479, bottommost pixel
FROG_SIZE, 4, sprite half-size
HOP_DIST, 32, pixels per hop; must be a multiple of HOP_FRAMES
HOP_FRAMES, 8, frames per hop animation
GOAL_Y, 35, landing at FrogY <= GOAL_Y scores a goal
DEATH_FRAMES, 60, frames frozen after death
LIVES_INIT, 3, lives at reset/restart

Ports:
frame_clk  in  1  ~60 Hz frame clock, sole clock
Reset  in  1  synchronous, active-high
keycode  in  16  current keyboard code
collision  in  1  frog overlaps hazard this frame
ride_dx  in  10  signed two's-complement drift from log/turtle under frog
FrogX  out  10  frog centre X
FrogY  out  10  frog centre Y
FrogS  out  10  constant FROG_SIZE
frog_state  out  2  IDLE=0, HOP=1, DYING=2, OVER=3
lives  out  2  remaining lives
goal_pulse  out  1  one-frame pulse on goal
game_over  out  1  high in OVER

Behaviour:
- All registers update on posedge frame_clk. Reset is sampled synchronously.
- Reset values: FrogX=X_START, FrogY=Y_START, state=IDLE, lives=LIVES_INIT, goal_pulse=0, game_over=0, hop_cnt=0, death_cnt=0, key_prev=0.
- Key edge detection:
  - key_prev <= keycode every frame, in every state.
  - A press is valid only when keycode != key_prev and keycode is one of 0x1A (up), 0x04 (left), 0x16 (down), 0x07 (right).
  - A held key produces exactly one press. Presses arriving during HOP, DYING or OVER are discarded, not queued.
- IDLE:
  - Priority: collision -> DYING; else valid in-bounds press -> HOP; else drift.
  - Bounds check, evaluated without underflow. The hop is allowed only if:
    - up: FrogY >= Y_MIN+FROG_SIZE+HOP_DIST
    - down: FrogY+HOP_DIST <= Y_MAX-FROG_SIZE
    - left: FrogX >= X_MIN+FROG_SIZE+HOP_DIST
    - right: FrogX+HOP_DIST <= X_MAX-FROG_SIZE
  - Out-of-bounds press: no state change, no movement.
  - Entering HOP: latch direction, hop_cnt=0.
  - Drift: FrogX += ride_dx (signed), saturated to [X_MIN+FROG_SIZE, X_MAX-FROG_SIZE]. FrogY unchanged.
- HOP:
  - Each frame, position moves STEP=HOP_DIST/HOP_FRAMES in the latched direction; hop_cnt++. ride_dx is ignored.
  - First step appears on the frame after the press is registered. The hop completes when the HOP_FRAMES-th step is applied; total displacement is exactly HOP_DIST.
  - collision in any HOP frame -> DYING immediately; position frozen at its current value.
  - On completion with new FrogY <= GOAL_Y: goal_pulse=1 for that single frame, position <= start, state=IDLE.
  - Otherwise completion -> IDLE.
- DYING:
  - Position frozen; inputs ignored; death_cnt counts 0..DEATH_FRAMES-1.
  - On the last count: if lives==1 -> lives=0, OVER. Else lives--, position <= start, IDLE.
- OVER:
  - game_over=1, position frozen.
  - A valid edge on keycode 0x28 (Enter) restores all reset values; the resulting state is IDLE.
- Simultaneous events: Reset > collision > goal > press > drift.
- Reset asserted mid-HOP or mid-DYING aborts to reset values on that edge.
- Width/arithmetic: 10-bit unsigned position. ride_dx is sign-extended, and the sum is computed in 11 bits before saturation.

Decomposition:
- Package frog_pkg holds:
  - frog_state_t enum
  - dir_t enum (UP, LEFT, DOWN, RIGHT)
  - keycode constants KEY_W=0x1A, KEY_A=0x04, KEY_S=0x16, KEY_D=0x07, KEY_ENTER=0x28
- Sub-module frog_key_edge holds key_prev and outputs a one-frame valid strobe plus decoded dir_t, and an enter_strobe.

Test Plan:
- Reset, then keycode 0x1A for 1 frame then 0 -> FrogY 431,427,...,403 over 8 frames; state HOP for 8 frames, then IDLE; FrogX=320.
- keycode 0x07 held 40 frames -> exactly one hop, FrogX 320->352; state returns to IDLE and stays there.
- FrogX=20 (via drift ride_dx=-1), press 0x04 -> no hop, FrogX stays 20. Continued drift saturates at FrogX=4.
- collision=1 at hop frame 3 -> DYING with position frozen, 60 frames later lives 3->2, FrogX/FrogY = 320/435, state IDLE.
- 13 up hops from reset (435-13*32=19 <= 35) -> goal_pulse high exactly one frame, position 320/435.
- Three deaths -> lives 0, game_over=1; 0x28 press -> lives=3, state IDLE, game_over=0. Reset asserted mid-hop -> reset values next edge.
